// File: rtl/seq_addsub_if.sv
// seq_addsub_if: operand/result handshake bundle for seq_addsub.
//   Input side : in_valid, in_ready, a, b, carry_in, op
//   Output side: out_valid, out_ready, sum, carry_out, overflow
//   sat is present only when SEQ_ADDSUB_SAT_EN is defined.
// Modports: master = producer/consumer around the adder, slave = the adder.
interface seq_addsub_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
`ifdef SEQ_ADDSUB_SAT_EN
  logic             sat;
`endif

  modport master (
`ifdef SEQ_ADDSUB_SAT_EN
    input  sat,
`endif
    output in_valid, a, b, carry_in, op, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
`ifdef SEQ_ADDSUB_SAT_EN
    output sat,
`endif
    input  in_valid, a, b, carry_in, op, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub: digit-serial adder/subtractor. Processes DIGIT bits of two WIDTH-bit operands
// per clock (NDIG = WIDTH/DIGIT cycles per operation) and reports sum, raw carry-out and
// signed overflow through valid/ready handshakes.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus_io : seq_addsub_if.slave (operands in, result out)
// WIDTH must be a multiple of DIGIT, and the interface WIDTH must match.
// Optional: define SEQ_ADDSUB_SAT_EN to saturate sum on overflow and drive bus_io.sat.
module seq_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input logic         clk,
  input logic         rst_n,
  seq_addsub_if.slave bus_io
);
  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CntW-1:0] LastDig = CntW'(NDIG - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;   // B already conditioned (inverted for subtract)
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             in_ready;
  logic             accept;
  logic             done;
  logic             ovf;
  int unsigned      dig_lo;
  logic [DIGIT:0]   dig_sum;

  assign done     = (state_q == StDone);
  assign in_ready = (state_q == StIdle) || (done && bus_io.out_ready);
  assign accept   = bus_io.in_valid && in_ready;

  // One narrow carry chain shared across all digits.
  always_comb begin
    dig_lo  = 32'(cnt_q) * DIGIT;
    dig_sum = {1'b0, a_q[dig_lo +: DIGIT]} + {1'b0, b_q[dig_lo +: DIGIT]}
            + {{DIGIT{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          // Subtract as a + ~b + ~carry_in, so a borrow-in becomes a missing carry.
          a_d     = bus_io.a;
          b_d     = bus_io.op ? ~bus_io.b : bus_io.b;
          carry_d = bus_io.op ? ~bus_io.carry_in : bus_io.carry_in;
          cnt_d   = '0;
          state_d = StRun;
        end else if (done && bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sum_d[dig_lo +: DIGIT] = dig_sum[DIGIT-1:0];
        carry_d                = dig_sum[DIGIT];
        if (cnt_q == LastDig) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // Same-sign operands producing a result of the other sign.
  assign ovf = done && (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = done;
  assign bus_io.carry_out = done && carry_q;
  assign bus_io.overflow  = ovf;

`ifdef SEQ_ADDSUB_SAT_EN
  // Clamp toward the sign of A: positive overflow -> 0x7F..F, negative -> 0x80..0.
  assign bus_io.sum = ovf ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : sum_q;
  assign bus_io.sat = ovf;
`else
  assign bus_io.sum = sum_q;
`endif

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: stimulus pushes model results, a negedge monitor checks
// every cycle a result is presented (stability under stall) and the accept-to-valid latency.
module tb_seq_addsub;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIGIT = 2;
  localparam int unsigned NDIG  = WIDTH / DIGIT;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ov;
    logic             sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_addsub_if #(.WIDTH(WIDTH)) bus ();

  seq_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   acc_q[$];
  int   ncyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  bit   seen_valid = 1'b0;
  bit   rnd_en = 1'b0;
  logic or_dir = 1'b1;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: integer arithmetic on the operands' unsigned and signed values.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic op);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int c  = int'(cin);
    int lim = 1 << (WIDTH - 1);
    int ru = op ? (ua - ub - c) : (ua + ub + c);
    int rs = op ? (sa - sb - c) : (sa + sb + c);
    e.sum = ru[WIDTH-1:0];
    e.co  = op ? (ru >= 0) : (ru >= (1 << WIDTH));
    e.ov  = (rs >= lim) || (rs < -lim);
    e.sat = 1'b0;
`ifdef SEQ_ADDSUB_SAT_EN
    if (e.ov) begin
      e.sum = (rs < 0) ? WIDTH'(lim) : WIDTH'(lim - 1);
      e.sat = 1'b1;
    end
`endif
    return e;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    int t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen_valid = 1'b0;
      end else if (bus.out_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          if (acc_q.size() == 0) fail_now("latency_no_accept");
          else begin
            t = acc_q.pop_front();
            chk("latency", ncyc - t, int'(NDIG) + 1);
          end
        end
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = exp_q[0];
          chk("sum", int'(bus.sum), int'(e.sum));
          chk("carry_out", int'(bus.carry_out), int'(e.co));
          chk("overflow", int'(bus.overflow), int'(e.ov));
`ifdef SEQ_ADDSUB_SAT_EN
          chk("sat", int'(bus.sat), int'(e.sat));
`endif
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  // Consumer
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rnd_en ? ($urandom_range(0, 3) != 0) : or_dir;
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic op, output int waits);
    waits = 0;
    @(posedge clk);
    #1;
    bus.a = a;
    bus.b = b;
    bus.carry_in = cin;
    bus.op = op;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 50) begin
        fail_now("accept_timeout");
        bus.in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(model(a, b, cin, op));
    acc_q.push_back(ncyc);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Post-acceptance garbage must not reach the result.
    bus.a = WIDTH'($urandom);
    bus.b = WIDTH'($urandom);
    bus.carry_in = 1'($urandom);
    bus.op = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    int w;
    int n;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.carry_in = 1'b0;
    bus.op = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_sum", int'(bus.sum), 0);
    chk("rst_carry_out", int'(bus.carry_out), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors
    do_op(8'd13, 8'd1, 1'b0, 1'b0, w);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, w);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, w);
    do_op(8'h05, 8'h07, 1'b0, 1'b1, w);
    do_op(8'h80, 8'h01, 1'b1, 1'b1, w);
    do_op(8'h00, 8'h00, 1'b1, 1'b1, w);
    drain();

    // Stall in DONE with changing inputs, then back-to-back accept
    or_dir = 1'b0;
    do_op(8'h21, 8'h12, 1'b1, 1'b0, w);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) fail_now("stall_no_valid");
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
    end
    or_dir = 1'b1;
    do_op(8'd3, 8'd4, 1'b0, 1'b0, w);
    chk("b2b_accept_wait", w, 0);
    drain();

    // Reset during RUN abandons the operation
    do_op(8'h55, 8'h22, 1'b1, 1'b0, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_sum", int'(bus.sum), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    do_op(8'h10, 8'h20, 1'b0, 1'b1, w);
    drain();

    // Random traffic with random back-pressure
    rnd_en = 1'b1;
    repeat (150) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), w);
    end
    drain();
    rnd_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
